// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the imem loader.
// The master side drives the stream, and the slave side is the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] WA;
    logic [DATA_WIDTH-1:0] WD;
    logic                  Busy;
    logic                  Done;
    logic                  Error;
    logic                  trigger;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, WE, WA, WD, Busy, Done, Error, trigger
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, WE, WA, WD, Busy, Done, Error, trigger
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a length-prefixed byte stream into 32-bit words, writes them to instruction memory,
// and then raises the CPU fetch enable (trigger).
//
// state   | meaning
// IDLE    | after reset, waiting for start
// HDR     | collecting the 16-bit little-endian word count
// LOAD    | assembling words; WE pulses one cycle after each 4th byte
// FLUSH   | write cycle of the final word; stream is closed
// DONE    | program loaded, trigger held high until the next start
// ERR     | header count exceeded capacity, nothing written
module imem_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_WORDS  = (1 << ADDR_WIDTH) / 4
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.slave  bus
);
    localparam int WIDX = $clog2(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q;
    logic [1:0]            byte_idx_q;
    logic [WIDX-1:0]       word_idx_q;
    logic [WIDX-1:0]       last_idx_q;
    logic [7:0]            hdr_lo_q;
    logic [23:0]           asm_q;
    logic                  rx_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] wa_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic                  trigger_q;

    logic                  accept;
    logic [15:0]           hdr_count;

    assign accept    = bus.rx_valid && rx_ready_q;
    assign hdr_count = {bus.rx_data, hdr_lo_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            last_idx_q <= '0;
            hdr_lo_q   <= '0;
            asm_q      <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            trigger_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q    <= S_HDR;
                        rx_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        trigger_q  <= 1'b0;
                        byte_idx_q <= '0;
                        word_idx_q <= '0;
                    end
                end

                S_HDR: begin
                    if (accept) begin
                        if (byte_idx_q == 2'd0) begin
                            hdr_lo_q   <= bus.rx_data;
                            byte_idx_q <= 2'd1;
                        end else begin
                            byte_idx_q <= '0;
                            // count <= MEM_WORDS here, so the low bits minus one give count-1
                            last_idx_q <= WIDX'(hdr_count[WIDX-1:0] - WIDX'(1));
                            if (hdr_count == 16'd0) begin
                                state_q    <= S_DONE;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                trigger_q  <= 1'b1;
                            end else if (hdr_count > 16'(MEM_WORDS)) begin
                                state_q    <= S_ERR;
                                rx_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0:    asm_q[7:0]   <= bus.rx_data;
                            2'd1:    asm_q[15:8]  <= bus.rx_data;
                            2'd2:    asm_q[23:16] <= bus.rx_data;
                            default: begin
                                we_q       <= 1'b1;
                                wa_q       <= ADDR_WIDTH'({word_idx_q, 2'b00});
                                wd_q       <= DATA_WIDTH'({bus.rx_data, asm_q});
                                word_idx_q <= word_idx_q + WIDX'(1);
                                if (word_idx_q == last_idx_q) begin
                                    state_q    <= S_FLUSH;
                                    rx_ready_q <= 1'b0;
                                end
                            end
                        endcase
                    end
                end

                S_FLUSH: begin
                    state_q   <= S_DONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    trigger_q <= 1'b1;
                end

                default: begin
                    state_q    <= S_IDLE;
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.WE       = we_q;
    assign bus.WA       = wa_q;
    assign bus.WD       = wd_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Error    = error_q;
    assign bus.trigger  = trigger_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory fetch path.
- Receives a program as a byte stream (valid/ready) and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses from 0.
- After the last write, releases the CPU by asserting the fetch-enable `trigger`, which gates PC register updates.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32, 4 bytes per word.
- ADDR_WIDTH, 12, byte-address width of instruction memory.
- MEM_WORDS, 1024, capacity in words (2^ADDR_WIDTH / 4); upper limit on program length.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- WE  output  1  instruction memory write enable.
- WA  output  ADDR_WIDTH  write byte address, word aligned.
- WD  output  DATA_WIDTH  write data.
- Busy  output  1  load in progress.
- Done  output  1  load completed successfully.
- Error  output  1  header length exceeded MEM_WORDS.
- trigger  output  1  CPU fetch enable (PC update enable).

Behaviour:
- Byte transfer: a byte is accepted only when rx_valid && rx_ready on a rising clk edge. rx_data is ignored otherwise.
- Reset (async, rst_n=0): state IDLE. All outputs 0, word index 0, byte index 0. Reset mid-load abandons the load; no further WE after reset asserts.
- States: IDLE, HDR, LOAD, FLUSH, DONE, ERR.
- IDLE
  - rx_ready=0, Busy=0.
  - start=1 → HDR next cycle; Done, Error and trigger clear on the same edge.
- HDR
  - rx_ready=1, Busy=1.
  - Accept 2 bytes: count = {byte1, byte0}, 16-bit little-endian.
  - On the second byte: count==0 → DONE; count>MEM_WORDS → ERR; else → LOAD.
- LOAD
  - rx_ready=1, Busy=1.
  - Byte index 0..3 fills WD bits [7:0], [15:8], [23:16], [31:24].
  - When the 4th byte is accepted, on the next cycle: WE=1 for exactly one cycle, WA = word_idx*4, WD = assembled word. word_idx then increments.
  - Byte acceptance continues during that write cycle for non-final words; there is no back-pressure.
  - If the 4th byte completes word count-1 → FLUSH.
- FLUSH (one cycle): rx_ready=0, Busy=1, WE=1 for the final word. Then → DONE.
- DONE
  - Done=1, trigger=1, rx_ready=0, Busy=0.
  - Held until start. start → HDR with Done=0 and trigger=0, so the CPU halts during a reload.
- ERR
  - Error=1, rx_ready=0, Busy=0, trigger=0.
  - No writes. start → HDR.
- start during HDR, LOAD or FLUSH is ignored.
- Latency: WE asserts exactly one cycle after acceptance of the 4th byte of each word.
- Words are 4-byte aligned; WA[1:0]=0 always.
- word_idx never exceeds count-1, so WA never wraps.
- WE is never asserted outside LOAD or FLUSH.
- trigger is a level: 0 from reset until the first successful load completes.

Test Plan:
1. Reset then idle
   - Stimulus: rst_n=0 for 2 cycles, then rx_valid=1 with no start.
   - Required: rx_ready, WE, Busy, Done, Error and trigger all 0; no byte accepted.
2. Two-word load, back-to-back bytes
   - Stimulus: start, then bytes 02 00 | 13 05 A0 00 | 93 05 15 00.
   - Required: WE at WA=0x000 with WD=0x00A00513, and at WA=0x004 with WD=0x00150593. Each WE is 1 cycle after the respective 4th byte. Then Done=1 and trigger=1.
3. Stalled stream
   - Stimulus: same program as scenario 2, with rx_valid toggling 1/0 each cycle.
   - Required: identical WE/WA/WD sequence; no byte is lost or duplicated.
4. Oversize header
   - Stimulus: header 01 04 (count=1025).
   - Required: Error=1, rx_ready=0, no WE, trigger=0.
   - Then start followed by header 00 00 → Done=1, trigger=1, no WE.
5. Reset mid-load
   - Stimulus: assert rst_n=0 after 2 bytes of word 1.
   - Required: all outputs 0 immediately and no WE afterward.
   - A following full load writes from WA=0.
6. Reload
   - Stimulus: start while in DONE.
   - Required: trigger=0 and Done=0 on the next edge, Busy=1; a new one-word load writes at WA=0x000.
